// File: rtl/gpio_port.sv
// rtl/gpio_port.sv - memory-mapped GPIO: LED register, debounced switches, sticky change flag (optional LED toggle via GPIO_TOGGLE_EN)
`timescale 1ns/1ps

module gpio_port #(
  parameter int          LED_WIDTH       = 8,
  parameter int          SW_WIDTH        = 8,
  parameter logic [31:0] LED_ADDR        = 32'h1001_0024,
  parameter logic [31:0] SW_ADDR         = 32'h1001_0028,
  parameter logic [31:0] TOGGLE_ADDR     = 32'h1001_002C,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 selector_gpio_i,
  input  logic [31:0]          Address_i,
  input  logic                 Mem_write_i,
  input  logic                 Mem_read_i,
  input  logic [31:0]          Write_data_i,
  input  logic [SW_WIDTH-1:0]  Switches_i,
  output logic [LED_WIDTH-1:0] Leds_o,
  output logic [31:0]          Read_data_o,
  output logic                 Change_flag_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync_meta;
  logic [SW_WIDTH-1:0] sync_s;
  logic [SW_WIDTH-1:0] candidate;
  logic [SW_WIDTH-1:0] debounced;
  logic [CNT_W-1:0]    counter;

  logic led_write_hit;
  logic sw_read_hit;
  logic stable;
  logic accept;
  logic debounced_change;

  // Only the low LED_WIDTH data bits reach the LEDs; the rest is intentionally dropped.
  logic unused_wdata;
  assign unused_wdata = ^Write_data_i;

  assign led_write_hit = selector_gpio_i && Mem_write_i && (Address_i == LED_ADDR);
  assign sw_read_hit   = selector_gpio_i && Mem_read_i  && (Address_i == SW_ADDR);

  // The candidate has been seen unchanged long enough to become the debounced value.
  assign stable           = (sync_s == candidate);
  assign accept           = stable && (counter == CNT_MAX);
  assign debounced_change = accept && (candidate != debounced);

`ifdef GPIO_TOGGLE_EN
  logic led_toggle_hit;
  assign led_toggle_hit = selector_gpio_i && Mem_write_i && (Address_i == TOGGLE_ADDR);
`endif

  // LED register: plain store, or XOR toggle when the toggle address is enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Leds_o <= '0;
    end else if (led_write_hit) begin
      Leds_o <= Write_data_i[LED_WIDTH-1:0];
`ifdef GPIO_TOGGLE_EN
    end else if (led_toggle_hit) begin
      Leds_o <= Leds_o ^ Write_data_i[LED_WIDTH-1:0];
`endif
    end
  end

  // Two-flop synchronizer; the raw pins feed nothing else.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= Switches_i;
      sync_s    <= sync_meta;
    end
  end

  // Debounce: restart on any change, accept once the candidate has stayed put long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      candidate <= '0;
      counter   <= '0;
      debounced <= '0;
    end else if (!stable) begin
      candidate <= sync_s;
      counter   <= '0;
    end else if (accept) begin
      debounced <= candidate;
    end else begin
      counter <= counter + CNT_W'(1);
    end
  end

  // Sticky change flag: a new debounced value beats a simultaneous clearing read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Change_flag_o <= 1'b0;
    end else if (debounced_change) begin
      Change_flag_o <= 1'b1;
    end else if (sw_read_hit) begin
      Change_flag_o <= 1'b0;
    end
  end

  // Single-cycle read path from registered state only; the flag rides in bit 31 when free.
  always_comb begin
    Read_data_o = '0;
    if (sw_read_hit) begin
      Read_data_o[SW_WIDTH-1:0] = debounced;
      if (SW_WIDTH < 32) begin
        Read_data_o[31] = Change_flag_o;
      end
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// tb/tb_gpio_port.sv - directed self-checking bench for gpio_port
`timescale 1ns/1ps

module tb_gpio_port;

  localparam logic [31:0] LED_ADDR    = 32'h1001_0024;
  localparam logic [31:0] SW_ADDR     = 32'h1001_0028;
  localparam logic [31:0] TOGGLE_ADDR = 32'h1001_002C;

  logic        clk;
  logic        reset;
  logic        selector_gpio_i;
  logic [31:0] Address_i;
  logic        Mem_write_i;
  logic        Mem_read_i;
  logic [31:0] Write_data_i;
  logic [7:0]  Switches_i;
  logic [7:0]  Leds_o;
  logic [31:0] Read_data_o;
  logic        Change_flag_o;

  int checks;
  int errors;
  logic [31:0] rd;

  gpio_port dut (
    .clk             (clk),
    .reset           (reset),
    .selector_gpio_i (selector_gpio_i),
    .Address_i       (Address_i),
    .Mem_write_i     (Mem_write_i),
    .Mem_read_i      (Mem_read_i),
    .Write_data_i    (Write_data_i),
    .Switches_i      (Switches_i),
    .Leds_o          (Leds_o),
    .Read_data_o     (Read_data_o),
    .Change_flag_o   (Change_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the store is clocked at the next posedge, returns at the following negedge.
  task automatic do_write(input logic sel, input logic [31:0] addr, input logic [31:0] data);
    selector_gpio_i = sel;
    Mem_write_i     = 1'b1;
    Address_i       = addr;
    Write_data_i    = data;
    @(negedge clk);
    selector_gpio_i = 1'b0;
    Mem_write_i     = 1'b0;
    Address_i       = 32'h0;
    Write_data_i    = 32'h0;
  endtask

  // Combinational read peek between edges; strobes drop before the next posedge.
  task automatic peek(input logic sel, input logic [31:0] addr, output logic [31:0] data);
    selector_gpio_i = sel;
    Mem_read_i      = 1'b1;
    Address_i       = addr;
    #1;
    data            = Read_data_o;
    selector_gpio_i = 1'b0;
    Mem_read_i      = 1'b0;
    Address_i       = 32'h0;
    #1;
  endtask

  // Read hit held across one posedge; data sampled before that edge.
  task automatic read_across_edge(output logic [31:0] data);
    selector_gpio_i = 1'b1;
    Mem_read_i      = 1'b1;
    Address_i       = SW_ADDR;
    #1;
    data = Read_data_o;
    @(negedge clk);
    selector_gpio_i = 1'b0;
    Mem_read_i      = 1'b0;
    Address_i       = 32'h0;
  endtask

  // Drive a switch value for n sampling edges, then return to zero.
  task automatic pulse(input logic [7:0] val, input int n);
    @(negedge clk);
    Switches_i = val;
    repeat (n) @(negedge clk);
    Switches_i = 8'h00;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset           = 1'b1;
    selector_gpio_i = 1'b0;
    Address_i       = 32'h0;
    Mem_write_i     = 1'b0;
    Mem_read_i      = 1'b0;
    Write_data_i    = 32'h0;
    Switches_i      = 8'h00;

    // Reset state
    @(negedge clk);
    check("rst_leds", {24'h0, Leds_o}, 32'h0);
    check("rst_flag", {31'h0, Change_flag_o}, 32'h0);
    check("rst_rdata_idle", Read_data_o, 32'h0);
    peek(1'b1, SW_ADDR, rd);
    check("rst_rdata_hit", rd, 32'h0);
    reset = 1'b0;

    // Asynchronous reset mid-cycle
    @(negedge clk);
    do_write(1'b1, LED_ADDR, 32'h0000_00FF);
    check("led_ff", {24'h0, Leds_o}, 32'hFF);
    #2 reset = 1'b1;
    #1;
    check("async_rst_leds", {24'h0, Leds_o}, 32'h0);
    check("async_rst_flag", {31'h0, Change_flag_o}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // LED writes and non-hits
    @(negedge clk);
    do_write(1'b1, LED_ADDR, 32'hDEAD_BEA5);
    check("led_write", {24'h0, Leds_o}, 32'hA5);
    do_write(1'b0, LED_ADDR, 32'h1234_5611);
    check("led_nosel", {24'h0, Leds_o}, 32'hA5);
    do_write(1'b1, SW_ADDR, 32'h1234_5611);
    check("led_wrong_addr", {24'h0, Leds_o}, 32'hA5);

    // Read non-hits return zero
    peek(1'b0, SW_ADDR, rd);
    check("read_nosel", rd, 32'h0);
    peek(1'b1, LED_ADDR, rd);
    check("read_led_addr", rd, 32'h0);

    // Glitches of 3 and 4 synchronized cycles are rejected
    pulse(8'h01, 3);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("glitch3_flag", {31'h0, Change_flag_o}, 32'h0);
    end
    peek(1'b1, SW_ADDR, rd);
    check("glitch3_rdata", rd, 32'h0);
    pulse(8'h01, 4);
    repeat (12) @(negedge clk);
    check("glitch4_flag", {31'h0, Change_flag_o}, 32'h0);
    peek(1'b1, SW_ADDR, rd);
    check("glitch4_rdata", rd, 32'h0);

    // A 5-cycle pulse is accepted, then the return to zero is accepted too
    pulse(8'h01, 5);
    repeat (14) @(negedge clk);
    check("pulse5_flag", {31'h0, Change_flag_o}, 32'h1);
    peek(1'b1, SW_ADDR, rd);
    check("pulse5_rdata", rd, 32'h8000_0000);
    read_across_edge(rd);
    check("pulse5_clear_rd", rd, 32'h8000_0000);
    check("pulse5_cleared", {31'h0, Change_flag_o}, 32'h0);

    // Debounce acceptance latency: visible only after edge k+6
    @(negedge clk);
    Switches_i = 8'h3C;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      peek(1'b1, SW_ADDR, rd);
      check($sformatf("accept_rdata_k%0d", j), rd, (j == 6) ? 32'h8000_003C : 32'h0);
      check($sformatf("accept_flag_k%0d", j), {31'h0, Change_flag_o}, (j == 6) ? 32'h1 : 32'h0);
    end

    // Flag clear by a read hit
    read_across_edge(rd);
    check("clear_rd", rd, 32'h8000_003C);
    check("clear_flag", {31'h0, Change_flag_o}, 32'h0);
    peek(1'b1, SW_ADDR, rd);
    check("clear_rdata_after", rd, 32'h0000_003C);

    // Read hit on the same edge as a new debounced value: set wins
    Switches_i = 8'h55;
    repeat (6) @(negedge clk);
    read_across_edge(rd);
    check("collide_rd", rd, 32'h0000_003C);
    check("collide_flag", {31'h0, Change_flag_o}, 32'h1);
    peek(1'b1, SW_ADDR, rd);
    check("collide_rdata_after", rd, 32'h8000_0055);

    // Toggle address
    do_write(1'b1, LED_ADDR, 32'h0000_00F0);
    check("led_f0", {24'h0, Leds_o}, 32'hF0);
    do_write(1'b1, TOGGLE_ADDR, 32'h0000_003C);
`ifdef GPIO_TOGGLE_EN
    check("toggle_leds", {24'h0, Leds_o}, 32'hCC);
`else
    check("toggle_leds", {24'h0, Leds_o}, 32'hF0);
`endif
    peek(1'b1, TOGGLE_ADDR, rd);
    check("toggle_read", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
